// File: rtl/spi_cmd_dispatcher_pkg.sv
// Shared definitions for the SPI command dispatcher: frame field positions,
// opcodes, error codes and FSM states.
package spi_cmd_dispatcher_pkg;

  localparam int OP_MSB      = 40;
  localparam int OP_LSB      = 37;
  localparam int CH_MSB      = 36;
  localparam int CH_LSB      = 34;
  localparam int RSVD_MSB    = 33;
  localparam int RSVD_LSB    = 32;
  localparam int PAYLOAD_MSB = 31;

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_CHRST  = 4'h2;
  localparam logic [3:0] OP_STATUS = 4'h8;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_OP      = 3'd2;
  localparam logic [2:0] ERR_CH      = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // Writers may raise busy up to 2 cycles after start, so busy is ignored this long.
  localparam logic [1:0] GRACE_CYC = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPATCH,
    ST_WAIT,
    ST_ERR,
    ST_ACK
  } state_e;

endpackage

// File: rtl/spi_cmd_dispatcher.sv
// Consumes completed SPI command frames, validates them and hands WRITE payloads
// or soft-reset pulses to one of CH_NUM PLL config writers; tracks errors.
module spi_cmd_dispatcher
  import spi_cmd_dispatcher_pkg::*;
#(
  parameter int CMD_BIT_NUM = 41,
  parameter int CH_NUM      = 6,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CMD_BIT_NUM-1:0] cmd_data,
  input  logic [6:0]             cmd_num,
  input  logic                   cmd_dready,
  output logic                   cmd_ack,
  output logic [CH_NUM-1:0]      ch_start,
  output logic [CH_NUM-1:0]      ch_rst,
  output logic [31:0]            ch_word,
  input  logic [CH_NUM-1:0]      ch_busy,
  output logic [7:0]             err_cnt,
  output logic [2:0]             err_code,
  output logic                   disp_busy
);

  function automatic logic [CH_NUM-1:0] ch_onehot(input logic [2:0] idx);
    ch_onehot = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (idx == 3'(i)) ch_onehot[i] = 1'b1;
    end
  endfunction

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [2:0]          ch_q, ch_d;
  logic [31:0]         payload_q, payload_d;
  logic [6:0]          num_q, num_d;
  logic [2:0]          code_q, code_d;
  logic [1:0]          grace_q, grace_d;
  logic [15:0]         timer_q, timer_d;
  logic [CH_NUM-1:0]   ch_start_q, ch_start_d;
  logic [CH_NUM-1:0]   ch_rst_q, ch_rst_d;
  logic [31:0]         ch_word_q, ch_word_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [2:0]          err_code_q, err_code_d;
  logic                ack_q, disp_busy_q;

  logic [CH_NUM-1:0]   sel;
  logic                sel_busy;
  logic                ch_invalid;
  logic                op_known;
  state_e              done_state;
  logic                rsvd_unused;

  assign rsvd_unused = ^cmd_data[RSVD_MSB:RSVD_LSB];
  assign sel         = ch_onehot(ch_q);
  assign sel_busy    = |(ch_busy & sel);
  assign ch_invalid  = ({1'b0, ch_q} >= 4'(CH_NUM));
  assign op_known    = (op_q == OP_WRITE) || (op_q == OP_CHRST);
  // A master that dropped dready early gets no ack handshake.
  assign done_state  = cmd_dready ? ST_ACK : ST_IDLE;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ch_d       = ch_q;
    payload_d  = payload_q;
    num_d      = num_q;
    code_d     = code_q;
    grace_d    = grace_q;
    timer_d    = timer_q;
    ch_start_d = '0;
    ch_rst_d   = '0;
    ch_word_d  = ch_word_q;
    err_cnt_d  = err_cnt_q;
    err_code_d = err_code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_dready) begin
          op_d      = cmd_data[OP_MSB:OP_LSB];
          ch_d      = cmd_data[CH_MSB:CH_LSB];
          payload_d = cmd_data[PAYLOAD_MSB:0];
          num_d     = cmd_num;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (num_q != 7'(CMD_BIT_NUM) && op_q != OP_STATUS) begin
          code_d  = ERR_LEN;
          state_d = ST_ERR;
        end else if (op_q == OP_STATUS) begin
          state_d = done_state;
        end else if (!op_known) begin
          code_d  = ERR_OP;
          state_d = ST_ERR;
        end else if (ch_invalid) begin
          code_d  = ERR_CH;
          state_d = ST_ERR;
        end else if (op_q == OP_WRITE) begin
          state_d = ST_DISPATCH;
        end else begin
          ch_rst_d = sel;
          state_d  = done_state;
        end
      end
      ST_DISPATCH: begin
        ch_word_d  = payload_q;
        ch_start_d = sel;
        grace_d    = '0;
        timer_d    = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (grace_q != GRACE_CYC) begin
          grace_d = grace_q + 2'd1;
        end else if (!sel_busy) begin
          state_d = done_state;
        end else if (timer_q == 16'(TIMEOUT_CYC)) begin
          code_d  = ERR_TIMEOUT;
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_ERR: begin
        err_code_d = code_q;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        state_d = done_state;
      end
      ST_ACK: begin
        if (!cmd_dready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      ch_q        <= '0;
      payload_q   <= '0;
      num_q       <= '0;
      code_q      <= ERR_NONE;
      grace_q     <= '0;
      timer_q     <= '0;
      ch_start_q  <= '0;
      ch_rst_q    <= '0;
      ch_word_q   <= '0;
      err_cnt_q   <= '0;
      err_code_q  <= ERR_NONE;
      ack_q       <= 1'b0;
      disp_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ch_q        <= ch_d;
      payload_q   <= payload_d;
      num_q       <= num_d;
      code_q      <= code_d;
      grace_q     <= grace_d;
      timer_q     <= timer_d;
      ch_start_q  <= ch_start_d;
      ch_rst_q    <= ch_rst_d;
      ch_word_q   <= ch_word_d;
      err_cnt_q   <= err_cnt_d;
      err_code_q  <= err_code_d;
      ack_q       <= (state_d == ST_ACK);
      disp_busy_q <= (state_d != ST_IDLE);
    end
  end

  assign cmd_ack   = ack_q;
  assign ch_start  = ch_start_q;
  assign ch_rst    = ch_rst_q;
  assign ch_word   = ch_word_q;
  assign err_cnt   = err_cnt_q;
  assign err_code  = err_code_q;
  assign disp_busy = disp_busy_q;

endmodule

// File: tb/tb_spi_cmd_dispatcher.sv
// Self-checking bench for spi_cmd_dispatcher: directed table, hand-written corner
// sequences and randomized frames against a timeline-level reference model.
module tb_spi_cmd_dispatcher;

  localparam int CH_NUM    = 6;
  localparam int TIMEOUT   = 100;
  localparam int NBITS     = 41;
  localparam int START_CYC = 3;    // dready set at cycle 0, ch_start seen 2 edges after sampling
  localparam int BUDGET    = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NBITS-1:0]  cmd_data = '0;
  logic [6:0]        cmd_num = '0;
  logic              cmd_dready = 1'b0;
  logic              cmd_ack;
  logic [CH_NUM-1:0] ch_start, ch_rst;
  logic [31:0]       ch_word;
  logic [CH_NUM-1:0] ch_busy = '0;
  logic [7:0]        err_cnt;
  logic [2:0]        err_code;
  logic              disp_busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] m_err_cnt = 8'd0;
  logic [2:0] m_err_code = 3'd0;

  always #5 clk = ~clk;

  spi_cmd_dispatcher #(.CMD_BIT_NUM(NBITS), .CH_NUM(CH_NUM), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_num(cmd_num), .cmd_dready(cmd_dready),
    .cmd_ack(cmd_ack), .ch_start(ch_start), .ch_rst(ch_rst), .ch_word(ch_word),
    .ch_busy(ch_busy), .err_cnt(err_cnt), .err_code(err_code), .disp_busy(disp_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Outcome of one frame computed from the frame rules and the writer's busy timeline.
  task automatic predict(input logic [3:0] op, input logic [2:0] ch, input logic [6:0] num,
                         input int d, input int len, output logic [2:0] err,
                         output logic do_start, output logic do_rst, output int ack_cyc);
    int last_busy;
    err = 3'd0; do_start = 1'b0; do_rst = 1'b0; ack_cyc = 2;
    if (op == 4'h8) ack_cyc = 2;
    else if (num != 7'(NBITS)) begin err = 3'd1; ack_cyc = 3; end
    else if (op != 4'h1 && op != 4'h2) begin err = 3'd2; ack_cyc = 3; end
    else if (int'(ch) >= CH_NUM) begin err = 3'd3; ack_cyc = 3; end
    else if (op == 4'h2) begin do_rst = 1'b1; ack_cyc = 2; end
    else begin
      do_start  = 1'b1;
      last_busy = (len == 0) ? 0 : d + len;   // first WAIT cycle with busy low
      if (last_busy > 3 + TIMEOUT) begin
        err     = 3'd4;
        ack_cyc = START_CYC + 3 + TIMEOUT + 2;
      end else begin
        ack_cyc = START_CYC + ((last_busy > 3) ? last_busy : 3) + 1;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [3:0] op, input logic [2:0] ch,
                           input logic [31:0] payload, input logic [6:0] num,
                           input int d, input int len, input int abort_at);
    logic [2:0] e_err; logic e_start, e_rst; int e_ack;
    int starts = 0, rsts = 0, start_cyc = -1, ack_cyc = -1, cyc = 0, since;
    logic [CH_NUM-1:0] start_val = '0, rst_val = '0, oh, busy_v;
    logic [31:0] word = '0;
    logic word_held = 1'b1, done = 1'b0;
    oh = (int'(ch) < CH_NUM) ? (CH_NUM'(1) << ch) : '0;
    predict(op, ch, num, d, len, e_err, e_start, e_rst, e_ack);
    if (abort_at > 0) e_ack = -1;
    @(negedge clk);
    cmd_data   = {op, ch, 2'($urandom), payload};
    cmd_num    = num;
    cmd_dready = 1'b1;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (ch_start != '0) begin starts++; start_val = ch_start; start_cyc = cyc; word = ch_word; end
      if (ch_rst != '0) begin rsts++; rst_val = ch_rst; end
      if (start_cyc >= 0 && ch_word != payload) word_held = 1'b0;
      if (cmd_ack && ack_cyc < 0) ack_cyc = cyc;
      if (cmd_ack) cmd_dready = 1'b0;
      if (abort_at > 0 && cyc == abort_at) cmd_dready = 1'b0;
      if (!disp_busy && !cmd_ack) done = 1'b1;
      busy_v = CH_NUM'($urandom) & ~oh;
      if (start_cyc >= 0) begin
        since = cyc - start_cyc;
        if (since >= d && since < d + len) busy_v = busy_v | oh;
      end
      ch_busy = done ? '0 : busy_v;
    end
    ch_busy    = '0;
    cmd_dready = 1'b0;
    if (e_err != 3'd0) begin
      m_err_code = e_err;
      if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
    end
    chk({tag, " completes"}, 64'(done), 64'd1);
    chk({tag, " start_count"}, 64'(starts), 64'(e_start ? 1 : 0));
    if (e_start) begin
      chk({tag, " start_onehot"}, 64'(start_val), 64'(oh));
      chk({tag, " start_latency"}, 64'(start_cyc), 64'(START_CYC));
      chk({tag, " ch_word"}, 64'(word), 64'(payload));
      chk({tag, " ch_word_held"}, 64'(word_held), 64'd1);
    end
    chk({tag, " rst_count"}, 64'(rsts), 64'(e_rst ? 1 : 0));
    if (e_rst) chk({tag, " rst_onehot"}, 64'(rst_val), 64'(oh));
    chk({tag, " ack_cycle"}, 64'(ack_cyc), 64'(e_ack));
    chk({tag, " err_code"}, 64'(err_code), 64'(m_err_code));
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'(m_err_cnt));
    $display("frame %s op=%h ch=%0d num=%0d ack_cyc=%0d err_code=%0d err_cnt=%0d",
             tag, op, ch, num, ack_cyc, err_code, err_cnt);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  ch;
    logic [31:0] payload;
    logic [6:0]  num;
    int          d;
    int          len;
    logic [2:0]  exp_code;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4'h1, 3'd2, 32'hA5A5_0001, 7'd41, 1, 10, 3'd0, 8'd0};
    tbl[1] = '{4'h1, 3'd2, 32'h1234_5678, 7'd40, 0, 0, 3'd1, 8'd1};
    tbl[2] = '{4'h8, 3'd0, 32'h0000_0000, 7'd13, 0, 0, 3'd1, 8'd1};
    tbl[3] = '{4'h1, 3'd7, 32'hCAFE_0000, 7'd41, 0, 0, 3'd3, 8'd2};
    tbl[4] = '{4'hF, 3'd0, 32'h0BAD_0BAD, 7'd41, 0, 0, 3'd2, 8'd3};
    tbl[5] = '{4'h2, 3'd5, 32'h0000_0000, 7'd41, 0, 0, 3'd2, 8'd3};
    tbl[6] = '{4'h1, 3'd0, 32'h0000_FFFF, 7'd41, 0, 0, 3'd2, 8'd3};

    repeat (3) @(negedge clk);
    chk("reset cmd_ack", 64'(cmd_ack), 64'd0);
    chk("reset ch_start", 64'(ch_start), 64'd0);
    chk("reset ch_rst", 64'(ch_rst), 64'd0);
    chk("reset ch_word", 64'(ch_word), 64'd0);
    chk("reset err_cnt", 64'(err_cnt), 64'd0);
    chk("reset err_code", 64'(err_code), 64'd0);
    chk("reset disp_busy", 64'(disp_busy), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].op, tbl[i].ch, tbl[i].payload, tbl[i].num,
                tbl[i].d, tbl[i].len, 0);
      chk($sformatf("tbl%0d table_err_code", i), 64'(err_code), 64'(tbl[i].exp_code));
      chk($sformatf("tbl%0d table_err_cnt", i), 64'(err_cnt), 64'(tbl[i].exp_cnt));
    end

    // Writer stuck busy, then a busy that falls exactly on the timeout cycle.
    run_frame("timeout", 4'h1, 3'd3, 32'h7777_0003, 7'd41, 0, 1000, 0);
    chk("timeout err_code", 64'(err_code), 64'd4);
    run_frame("after_timeout", 4'h1, 3'd1, 32'h0101_0101, 7'd41, 2, 4, 0);
    run_frame("edge_timeout", 4'h1, 3'd4, 32'h4444_4444, 7'd41, 2, 101, 0);
    run_frame("abort", 4'h1, 3'd4, 32'hABCD_EF01, 7'd41, 0, 20, 6);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op; logic [6:0] num; int r, len;
      r  = $urandom_range(0, 9);
      op = (r < 5) ? 4'h1 : (r < 7) ? 4'h2 : (r == 7) ? 4'h8 : 4'($urandom);
      num = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'd41;
      len = ($urandom_range(0, 9) == 0) ? 150 : $urandom_range(0, 12);
      run_frame($sformatf("rnd%0d", i), op, 3'($urandom_range(0, 7)), $urandom, num,
                $urandom_range(0, 2), len, 0);
    end

    // Reset while a writer is busy: everything drops without waiting for a clock.
    @(negedge clk);
    cmd_data = {4'h1, 3'd3, 2'b00, 32'hDEAD_BEEF};
    cmd_num = 7'd41;
    cmd_dready = 1'b1;
    begin
      int n = 0;
      while (ch_start == '0 && n < 10) begin @(negedge clk); n++; end
      chk("midwait start_seen", 64'(ch_start), 64'(6'b001000));
    end
    ch_busy = 6'b001000;
    repeat (2) @(negedge clk);
    chk("midwait busy_before", 64'(disp_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midwait ch_word", 64'(ch_word), 64'd0);
    chk("midwait ch_start", 64'(ch_start), 64'd0);
    chk("midwait ch_rst", 64'(ch_rst), 64'd0);
    chk("midwait cmd_ack", 64'(cmd_ack), 64'd0);
    chk("midwait disp_busy", 64'(disp_busy), 64'd0);
    chk("midwait err_cnt", 64'(err_cnt), 64'd0);
    chk("midwait err_code", 64'(err_code), 64'd0);
    $display("frame midwait_reset applied");
    cmd_dready = 1'b0;
    ch_busy = '0;
    m_err_cnt = 8'd0;
    m_err_code = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset idle", 64'(disp_busy), 64'd0);
    run_frame("post_reset", 4'h1, 3'd5, 32'h5555_AAAA, 7'd41, 1, 3, 0);
    run_frame("chrst5", 4'h2, 3'd5, 32'h0, 7'd41, 0, 0, 0);

    for (int i = 0; i < 260; i++)
      run_frame($sformatf("sat%0d", i), 4'hF, 3'd0, 32'h0, 7'd41, 0, 0, 0);
    chk("saturated err_cnt", 64'(err_cnt), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
